// File: rtl/spi_master_mm.sv
// Memory-mapped SPI master (mode 0, MSB first) with a one-entry TX holding
// register, an RX register with overrun flag and a level receive interrupt.
module spi_master_mm #(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [4:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n,
  output logic        irq,
  output logic        dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d, served_q, served_d;
  logic [31:0] data_q, data_d;
  logic        en_q, en_d, irq_en_q, irq_en_d, cs_q, cs_d;
  logic [7:0]  div_q, div_d, div_lat_q, div_lat_d, cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d, shift_q, shift_d, rx_q, rx_d;
  logic        tx_full_q, tx_full_d, rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic [3:0]  half_q, half_d;
  logic        sclk_q, sclk_d, mosi_q, mosi_d;

  logic        access, wr, rd, rd_rx;
  logic [2:0]  widx;
  logic        unused_bits;

  // Bus handshake: an access is taken on the first cycle select is seen with
  // no access outstanding; ready pulses once and stays low until select drops.
  assign access = select & ~served_q;
  assign wr     = access & (wstrb != 4'b0000);
  assign rd     = access & (wstrb == 4'b0000);
  assign widx   = addr[4:2];
  assign rd_rx  = rd & (widx == 3'd3);
  assign unused_bits = ^{data_i[31:16], addr[1:0]};

  always_comb begin
    state_d    = state_q;
    ready_d    = access;
    served_d   = select & (served_q | access);
    data_d     = 32'd0;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    cs_d       = cs_q;
    div_d      = div_q;
    div_lat_d  = div_lat_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    tx_full_d  = tx_full_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    half_d     = half_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;

    if (rd) begin
      case (widx)
        3'd0:    data_d = {16'd0, div_q, 6'd0, irq_en_q, en_q};
        3'd1:    data_d = {28'd0, rx_ovr_q, rx_valid_q, tx_full_q, state_q == S_SHIFT};
        3'd3:    data_d = {24'd0, rx_q};
        3'd4:    data_d = {31'd0, cs_q};
        default: data_d = 32'd0;
      endcase
    end

    if (wr && widx == 3'd0) begin
      if (wstrb[0]) {irq_en_d, en_d} = data_i[1:0];
      if (wstrb[1]) div_d = data_i[15:8];
    end
    if (wr && widx == 3'd4 && wstrb[0]) cs_d = data_i[0];
    if (wr && widx == 3'd2 && wstrb[0] && !tx_full_q && en_q) begin
      hold_d    = data_i[7:0];
      tx_full_d = 1'b1;
    end
    if (wr && widx == 3'd1 && wstrb[0] && data_i[3]) rx_ovr_d = 1'b0;
    if (rd_rx) rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en_q && tx_full_q) begin
          shift_d   = hold_q;
          tx_full_d = 1'b0;
          mosi_d    = hold_q[7];
          div_lat_d = div_q;
          cnt_d     = 8'd0;
          half_d    = 4'd0;
          sclk_d    = 1'b0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!en_q) begin
          sclk_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == div_lat_q) begin
          cnt_d  = 8'd0;
          half_d = half_q + 4'd1;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            shift_d = {shift_q[6:0], miso};
          end else if (half_q == 4'd15) begin
            // A completing byte beats a same-cycle RXDATA read: no overrun.
            rx_d       = shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rd_rx) rx_ovr_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            mosi_d = shift_q[7];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!en_q) tx_full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      served_q   <= 1'b0;
      data_q     <= 32'd0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      cs_q       <= 1'b0;
      div_q      <= DIV_RESET;
      div_lat_q  <= DIV_RESET;
      cnt_q      <= 8'd0;
      hold_q     <= 8'd0;
      shift_q    <= 8'd0;
      rx_q       <= 8'd0;
      tx_full_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      half_q     <= 4'd0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      served_q   <= served_d;
      data_q     <= data_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      cs_q       <= cs_d;
      div_q      <= div_d;
      div_lat_q  <= div_lat_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      tx_full_q  <= tx_full_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      half_q     <= half_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
    end
  end

  assign ready       = ready_q;
  assign data_o      = data_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs_n        = ~cs_q;
  assign irq         = rx_valid_q & irq_en_q;
  assign dbg_state_o = (state_q == S_SHIFT);

endmodule

// File: tb/tb_spi_master_mm.sv
// Directed bench for spi_master_mm: miso is looped back to mosi, sclk rises
// are logged by a monitor and compared against an expected bit queue.
module tb_spi_master_mm;

  logic        clk = 1'b0;
  logic        reset, select, miso;
  logic [3:0]  wstrb;
  logic [4:0]  addr;
  logic [31:0] data_i, data_o;
  logic        ready, sclk, mosi, cs_n, irq, dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  spi_master_mm #(.DIV_RESET(8'd3)) dut (
    .clk(clk), .reset(reset), .select(select), .wstrb(wstrb), .addr(addr),
    .data_i(data_i), .ready(ready), .data_o(data_o), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n), .irq(irq), .dbg_state_o(dbg_state)
  );

  assign miso = mosi;

  // monitor: mosi at each sclk rise, rise times, busy cycles
  int       cyc = 0;
  int       rise_cnt = 0;
  int       busy_cyc = 0;
  int       rise_t[$];
  logic     sclk_prev = 1'b0;
  logic [0:0] got_q[$];
  logic [0:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (sclk && !sclk_prev) begin
      rise_cnt++;
      rise_t.push_back(cyc);
      got_q.push_back(mosi);
    end
    sclk_prev = sclk;
    if (dbg_state) busy_cyc++;
  end

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rise_cnt = 0;
    busy_cyc = 0;
    rise_t.delete();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic check_bits(input string tag);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk(tag, {31'd0, got_q.pop_front()}, {31'd0, exp_q.pop_front()});
  endtask

  // driver tasks
  task automatic bus(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] r);
    int n;
    @(posedge clk); #1;
    select = 1'b1; addr = a; wstrb = s; data_i = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ready !== 1'b1 && n < 8);
    r = data_o;
    chk("bus_ready", {31'd0, ready}, 32'd1);
    select = 1'b0; wstrb = 4'd0; data_i = 32'd0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    bus(a, s, d, r);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 4'd0, 32'd0, r);
    chk(tag, r, exp);
  endtask

  task automatic wait_rises(input int n, input int budget, input string tag);
    int k = 0;
    while (rise_cnt < n && k < budget) begin @(posedge clk); #2; k++; end
    chk(tag, 32'(rise_cnt), 32'(n));
  endtask

  initial begin
    int n;
    reset = 1'b1; select = 1'b0; wstrb = 4'd0; addr = 5'd0; data_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_data_o", data_o, 32'd0);
    reset = 1'b0;
    rd_chk("rst_ctrl", 5'h00, 32'h0000_0300);
    rd_chk("rst_status", 5'h04, 32'h0);
    rd_chk("rst_rxdata", 5'h0C, 32'h0);

    // single byte 0xA5, div 0
    wr(5'h00, 32'h0000_0003, 4'b0011);
    rd_chk("ctrl_div0", 5'h00, 32'h0000_0003);
    wr(5'h10, 32'h1, 4'b0001);
    chk("cs_n_low", {31'd0, cs_n}, 32'd0);
    rd_chk("cs_read", 5'h10, 32'h1);
    clear_mon();
    push_byte(8'hA5);
    wr(5'h08, 32'hA5, 4'b0001);
    wait_rises(8, 100, "a5_rises");
    repeat (3) @(posedge clk);
    #2;
    chk("a5_busy_cycles", 32'(busy_cyc), 32'd16);
    chk("a5_sclk_span", 32'(rise_t[7] - rise_t[0]), 32'd14);
    check_bits("a5_mosi");
    chk("a5_irq_high", {31'd0, irq}, 32'd1);
    rd_chk("a5_status", 5'h04, 32'h4);
    rd_chk("a5_rxdata", 5'h0C, 32'hA5);
    chk("a5_irq_low", {31'd0, irq}, 32'd0);

    // back-to-back 0x3C, 0xC3; 0xFF dropped; overrun
    clear_mon();
    push_byte(8'h3C);
    push_byte(8'hC3);
    wr(5'h08, 32'h3C, 4'b0001);
    wr(5'h08, 32'hC3, 4'b0001);
    rd_chk("b2b_status_full", 5'h04, 32'h3);
    wr(5'h08, 32'hFF, 4'b0001);
    wait_rises(16, 200, "b2b_rises");
    repeat (40) @(posedge clk);
    #2;
    chk("b2b_no_ff", 32'(rise_cnt), 32'd16);
    chk("b2b_busy_cycles", 32'(busy_cyc), 32'd32);
    chk("b2b_gap", 32'(rise_t[8] - rise_t[7]), 32'd3);
    check_bits("b2b_mosi");
    rd_chk("ovr_status", 5'h04, 32'h0C);
    rd_chk("ovr_rxdata", 5'h0C, 32'hC3);
    rd_chk("ovr_status_after_rd", 5'h04, 32'h08);
    wr(5'h04, 32'h8, 4'b0001);
    rd_chk("ovr_cleared", 5'h04, 32'h0);

    // abort at 5th sclk rise, div 3
    wr(5'h00, 32'h0000_0303, 4'b0011);
    clear_mon();
    wr(5'h08, 32'h5A, 4'b0001);
    wait_rises(5, 200, "abort_rises");
    wr(5'h00, 32'h0000_0302, 4'b0011);
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, dbg_state}, 32'd0);
    chk("abort_sclk", {31'd0, sclk}, 32'd0);
    repeat (50) @(posedge clk);
    #2;
    chk("abort_no_more_rises", 32'(rise_cnt), 32'd5);
    rd_chk("abort_status", 5'h04, 32'h0);
    rd_chk("abort_rxdata", 5'h0C, 32'hC3);

    // select held 4 cycles: one ready pulse
    @(posedge clk); #1;
    select = 1'b1; addr = 5'h04; wstrb = 4'd0;
    n = 0;
    repeat (4) begin @(posedge clk); #1; if (ready) n++; end
    select = 1'b0;
    chk("hold_ready_pulses", 32'(n), 32'd1);
    @(posedge clk); #1;
    chk("hold_data_o_idle", data_o, 32'd0);
    rd_chk("unmapped_0x14", 5'h14, 32'h0);

    // reset mid-transfer
    wr(5'h00, 32'h0000_0001, 4'b0001);
    wr(5'h10, 32'h1, 4'b0001);
    wr(5'h08, 32'h81, 4'b0001);
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, dbg_state}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_sclk", {31'd0, sclk}, 32'd0);
    chk("mid_rst_mosi", {31'd0, mosi}, 32'd0);
    chk("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("mid_rst_busy", {31'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    rd_chk("mid_rst_rxdata", 5'h0C, 32'h0);
    rd_chk("mid_rst_status", 5'h04, 32'h0);
    rd_chk("mid_rst_ctrl", 5'h00, 32'h0000_0300);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
